rbt_s_eth_parser: RTL and testbench



---
 rtl/rbt_s_eth_parser.sv | 217 +++++++++++++++++++++
 tb/tb_rbt_s_eth_parser.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rbt_s_eth_parser.sv
`default_nettype none
// ============================================================================
// Module   : rbt_s_eth_parser
// Purpose  : First receive header-parse stage. Classifies a frame by its
//            EtherType (following up to MAX_VLAN stacked 802.1Q/802.1ad
//            tags), strips the L2 header, tags PHV word 0, advances the L3
//            offset byte and registers the result behind a 2-entry skid.
// Ports    : clk, rst_n (async, active-low)
//            in_proto_hdr_*   : valid/ready input beat (window, length, PHV)
//            out_proto_hdr_*  : valid/ready output beat (stripped window,
//                               remaining length, updated PHV)
//            stat_*_count     : accepted / IPv6-tagged / L2-error beat counts
// Revision : 1.0 - initial release
// ============================================================================
module rbt_s_eth_parser #(
  parameter int HEADER_WIDTH = 2048,
  parameter int PHV_WIDTH    = 408,
  parameter int PHV_B_NUM    = 7,
  parameter int PHV_H_NUM    = 2,
  parameter int PHV_W_NUM    = 10,
  parameter int MAX_VLAN     = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_proto_hdr_valid,
  output logic                    in_proto_hdr_ready,
  input  logic [15:0]             in_proto_hdr_length,
  input  logic [HEADER_WIDTH-1:0] in_proto_hdr_data,
  input  logic [PHV_WIDTH-1:0]    in_proto_hdr_phv,
  output logic                    out_proto_hdr_valid,
  input  logic                    out_proto_hdr_ready,
  output logic [HEADER_WIDTH-1:0] out_proto_hdr_data,
  output logic [15:0]             out_proto_hdr_length,
  output logic [PHV_WIDTH-1:0]    out_proto_hdr_phv,
  output logic [31:0]             stat_pkt_count,
  output logic [31:0]             stat_ipv6_count,
  output logic [31:0]             stat_err_count
);

  // PHV layout: bytes from the LSB, then halfwords, then words.
  localparam int c_B6_LSB   = 6 * 8;
  localparam int c_H0_LSB   = PHV_B_NUM * 8;
  localparam int c_H1_LSB   = c_H0_LSB + 16;
  localparam int c_W0_LSB   = PHV_B_NUM * 8 + PHV_H_NUM * 16;
  localparam int c_PHV_BITS = c_W0_LSB + PHV_W_NUM * 32;

  localparam int c_W0_VLAN  = c_W0_LSB + 1;
  localparam int c_W0_ARP   = c_W0_LSB + 2;
  localparam int c_W0_IPV4  = c_W0_LSB + 3;
  localparam int c_W0_IPV6  = c_W0_LSB + 4;
  localparam int c_W0_L2ERR = c_W0_LSB + 7;

  localparam bit c_TWO_TAGS = (MAX_VLAN >= 2);

  localparam logic [15:0] c_ET_CTAG = 16'h8100;
  localparam logic [15:0] c_ET_STAG = 16'h88A8;
  localparam logic [15:0] c_ET_IPV6 = 16'h86DD;
  localparam logic [15:0] c_ET_IPV4 = 16'h0800;
  localparam logic [15:0] c_ET_ARP  = 16'h0806;

  generate
    if ((c_PHV_BITS != PHV_WIDTH) || (MAX_VLAN < 1) || (MAX_VLAN > 2) ||
        ((HEADER_WIDTH % 8) != 0) || (HEADER_WIDTH < 22 * 8)) begin : g_param_check
      $error("rbt_s_eth_parser: inconsistent parameterisation");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Combinational parse of the incoming beat
  // --------------------------------------------------------------------------
  logic [7:0]              w_hb [0:21];
  logic [15:0]             w_et0, w_et1, w_et2, w_et_final;
  logic                    w_tag0, w_tag1, w_err;
  logic [15:0]             w_strip;
  logic [HEADER_WIDTH-1:0] w_data;
  logic [15:0]             w_length;
  logic [PHV_WIDTH-1:0]    w_phv;
  logic                    w_is_ipv6;

  always_comb begin
    for (int k = 0; k < 22; k++) begin
      w_hb[k] = in_proto_hdr_data[HEADER_WIDTH-1-8*k -: 8];
    end
  end

  always_comb begin
    w_et0  = {w_hb[12], w_hb[13]};
    w_et1  = {w_hb[16], w_hb[17]};
    w_et2  = {w_hb[20], w_hb[21]};
    w_tag0 = (w_et0 == c_ET_CTAG) || (w_et0 == c_ET_STAG);
    // Only a C-tag is recognised as the inner tag of a stacked pair.
    w_tag1 = c_TWO_TAGS && w_tag0 && (w_et1 == c_ET_CTAG);

    w_strip    = w_tag1 ? 16'd22 : (w_tag0 ? 16'd18 : 16'd14);
    w_et_final = w_tag1 ? w_et2  : (w_tag0 ? w_et1  : w_et0);
    w_err      = (in_proto_hdr_length < w_strip);

    w_phv     = in_proto_hdr_phv;
    w_data    = in_proto_hdr_data;
    w_length  = in_proto_hdr_length;
    w_is_ipv6 = 1'b0;

    if (w_err) begin
      // A truncated frame is forwarded untouched apart from the error flag,
      // so nothing derived from an incomplete header leaks into the PHV.
      w_phv[c_W0_L2ERR] = 1'b1;
    end else begin
      if (w_tag0) begin
        w_phv[c_H0_LSB +: 16] = {4'b0000, w_hb[14][3:0], w_hb[15]};
        w_phv[c_W0_VLAN]      = 1'b1;
      end
      if (w_tag1) begin
        w_phv[c_H1_LSB +: 16] = {4'b0000, w_hb[18][3:0], w_hb[19]};
      end
      if (w_et_final == c_ET_IPV6) begin
        w_phv[c_W0_IPV6] = 1'b1;
        w_is_ipv6        = 1'b1;
      end
      if (w_et_final == c_ET_IPV4) w_phv[c_W0_IPV4] = 1'b1;
      if (w_et_final == c_ET_ARP)  w_phv[c_W0_ARP]  = 1'b1;

      w_phv[c_B6_LSB +: 8] = in_proto_hdr_phv[c_B6_LSB +: 8] + w_strip[7:0];
      w_length             = in_proto_hdr_length - w_strip;

      // Three fixed shifters muxed, rather than one variable barrel shifter.
      if (w_tag1)      w_data = in_proto_hdr_data << (22 * 8);
      else if (w_tag0) w_data = in_proto_hdr_data << (18 * 8);
      else             w_data = in_proto_hdr_data << (14 * 8);
    end
  end

  // --------------------------------------------------------------------------
  // Output register + skid register
  // --------------------------------------------------------------------------
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic [HEADER_WIDTH-1:0] r_out_data;
  logic [15:0]             r_out_length;
  logic [PHV_WIDTH-1:0]    r_out_phv;
  logic                    r_skid_valid;
  logic [HEADER_WIDTH-1:0] r_skid_data;
  logic [15:0]             r_skid_length;
  logic [PHV_WIDTH-1:0]    r_skid_phv;
  logic [31:0]             r_pkt_count;
  logic [31:0]             r_ipv6_count;
  logic [31:0]             r_err_count;

  logic w_accept;
  logic w_drain;

  assign w_accept = in_proto_hdr_valid & r_in_ready;
  assign w_drain  = r_out_valid & out_proto_hdr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_length  <= '0;
      r_out_phv     <= '0;
      r_skid_valid  <= 1'b0;
      r_skid_data   <= '0;
      r_skid_length <= '0;
      r_skid_phv    <= '0;
      r_pkt_count   <= '0;
      r_ipv6_count  <= '0;
      r_err_count   <= '0;
    end else begin
      r_in_ready <= 1'b1;

      if (w_accept) begin
        r_pkt_count <= r_pkt_count + 32'd1;
        if (w_is_ipv6) r_ipv6_count <= r_ipv6_count + 32'd1;
        if (w_err)     r_err_count  <= r_err_count + 32'd1;
      end

      // in_ready is the registered complement of skid occupancy, so no
      // accept can arrive while the skid holds a beat.
      if (r_skid_valid) begin
        if (w_drain) begin
          r_out_data    <= r_skid_data;
          r_out_length  <= r_skid_length;
          r_out_phv     <= r_skid_phv;
          r_skid_valid  <= 1'b0;
        end else begin
          r_in_ready    <= 1'b0;
        end
      end else if (w_accept) begin
        if (!r_out_valid || w_drain) begin
          r_out_valid   <= 1'b1;
          r_out_data    <= w_data;
          r_out_length  <= w_length;
          r_out_phv     <= w_phv;
        end else begin
          r_skid_valid  <= 1'b1;
          r_skid_data   <= w_data;
          r_skid_length <= w_length;
          r_skid_phv    <= w_phv;
          r_in_ready    <= 1'b0;
        end
      end else if (w_drain) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_proto_hdr_ready   = r_in_ready;
  assign out_proto_hdr_valid  = r_out_valid;
  assign out_proto_hdr_data   = r_out_data;
  assign out_proto_hdr_length = r_out_length;
  assign out_proto_hdr_phv    = r_out_phv;
  assign stat_pkt_count       = r_pkt_count;
  assign stat_ipv6_count      = r_ipv6_count;
  assign stat_err_count       = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_rbt_s_eth_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_rbt_s_eth_parser
// Purpose  : Self-checking bench for rbt_s_eth_parser. A byte-level model of
//            the parse rules predicts every beat; a queue stands in for the
//            two buffer slots. A second instance with MAX_VLAN=1 runs on the
//            same input stream with a permanently ready output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rbt_s_eth_parser;

  localparam int HW = 2048;
  localparam int PW = 408;

  typedef struct {
    logic [HW-1:0] data;
    logic [15:0]   len;
    logic [PW-1:0] phv;
    bit            ipv6;
    bit            err;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [15:0]   in_len;
  logic [HW-1:0] in_data;
  logic [PW-1:0] in_phv;
  logic          out_ready;

  logic          in_ready, out_valid;
  logic [HW-1:0] out_data;
  logic [15:0]   out_len;
  logic [PW-1:0] out_phv;
  logic [31:0]   st_pkt, st_ipv6, st_err;

  logic          in_ready1, out_valid1;
  logic [HW-1:0] out_data1;
  logic [15:0]   out_len1;
  logic [PW-1:0] out_phv1;
  logic [31:0]   st_pkt1, st_ipv61, st_err1;

  always #5 clk = ~clk;

  rbt_s_eth_parser #(.MAX_VLAN(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_proto_hdr_valid(in_valid), .in_proto_hdr_ready(in_ready),
    .in_proto_hdr_length(in_len), .in_proto_hdr_data(in_data),
    .in_proto_hdr_phv(in_phv),
    .out_proto_hdr_valid(out_valid), .out_proto_hdr_ready(out_ready),
    .out_proto_hdr_data(out_data), .out_proto_hdr_length(out_len),
    .out_proto_hdr_phv(out_phv),
    .stat_pkt_count(st_pkt), .stat_ipv6_count(st_ipv6), .stat_err_count(st_err)
  );

  rbt_s_eth_parser #(.MAX_VLAN(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_proto_hdr_valid(in_valid), .in_proto_hdr_ready(in_ready1),
    .in_proto_hdr_length(in_len), .in_proto_hdr_data(in_data),
    .in_proto_hdr_phv(in_phv),
    .out_proto_hdr_valid(out_valid1), .out_proto_hdr_ready(1'b1),
    .out_proto_hdr_data(out_data1), .out_proto_hdr_length(out_len1),
    .out_proto_hdr_phv(out_phv1),
    .stat_pkt_count(st_pkt1), .stat_ipv6_count(st_ipv61), .stat_err_count(st_err1)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  res_t q[$];
  int   exp_pkt = 0, exp_ipv6 = 0, exp_err = 0;
  bit   exp1_valid = 0;
  res_t exp1;

  // --------------------------------------------------------------------------
  // Reference model: works on a byte array, PHV offsets written out literally
  // (B6 at 48, H0 at 56, H1 at 72, W0 at 88).
  // --------------------------------------------------------------------------
  function automatic res_t model(input logic [HW-1:0] d, input logic [15:0] len,
                                 input logic [PW-1:0] phv, input int maxv);
    res_t r;
    logic [7:0] b [256];
    int et, s, vid0, vid1;
    for (int i = 0; i < 256; i++) b[i] = d[HW-1-8*i -: 8];
    et = {b[12], b[13]};
    s = 14; vid0 = -1; vid1 = -1;
    if (et == 16'h8100 || et == 16'h88A8) begin
      vid0 = {b[14], b[15]} & 12'hFFF;
      s = 18;
      et = {b[16], b[17]};
      if (et == 16'h8100 && maxv == 2) begin
        vid1 = {b[18], b[19]} & 12'hFFF;
        s = 22;
        et = {b[20], b[21]};
      end
    end
    r.phv = phv;
    r.err = (int'(len) < s);
    r.ipv6 = 0;
    if (r.err) begin
      r.phv[88 + 7] = 1'b1;
      r.data = d;
      r.len = len;
    end else begin
      if (vid0 >= 0) begin
        r.phv[56 +: 16] = 16'(vid0);
        r.phv[88 + 1] = 1'b1;
      end
      if (vid1 >= 0) r.phv[72 +: 16] = 16'(vid1);
      if (et == 16'h86DD) begin r.phv[88 + 4] = 1'b1; r.ipv6 = 1; end
      if (et == 16'h0800) r.phv[88 + 3] = 1'b1;
      if (et == 16'h0806) r.phv[88 + 2] = 1'b1;
      r.phv[48 +: 8] = 8'((int'(phv[48 +: 8]) + s) % 256);
      r.len = 16'(int'(len) - s);
      r.data = '0;
      for (int i = 0; i + s < 256; i++) r.data[HW-1-8*i -: 8] = b[i + s];
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_wide(input string nm, input logic [HW-1:0] act, input logic [HW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got hi %h lo %h, expected hi %h lo %h (t=%0t)", nm,
               act[HW-1 -: 64], act[63:0], exp[HW-1 -: 64], exp[63:0], $time);
    end
  endtask

  task automatic compare();
    chk("out_valid", out_valid, q.size() != 0);
    chk("in_ready", in_ready, q.size() < 2);
    if (q.size() != 0 && out_valid) begin
      chk_wide("out_data", out_data, q[0].data);
      chk("out_length", out_len, q[0].len);
      chk_wide("out_phv", out_phv, q[0].phv);
    end
    chk("stat_pkt", st_pkt, exp_pkt);
    chk("stat_ipv6", st_ipv6, exp_ipv6);
    chk("stat_err", st_err, exp_err);
    chk("v1_out_valid", out_valid1, exp1_valid);
    if (exp1_valid && out_valid1) begin
      chk_wide("v1_out_data", out_data1, exp1.data);
      chk("v1_out_length", out_len1, exp1.len);
      chk_wide("v1_out_phv", out_phv1, exp1.phv);
    end
  endtask

  // Inputs are already driven; predict this edge, clock it, then compare.
  task automatic step();
    bit acc, drn, acc1;
    res_t r;
    acc  = in_valid && in_ready;
    drn  = out_valid && out_ready;
    acc1 = in_valid && in_ready1;
    if (drn && q.size() != 0) void'(q.pop_front());
    if (acc) begin
      r = model(in_data, in_len, in_phv, 2);
      q.push_back(r);
      exp_pkt++;
      if (r.ipv6) exp_ipv6++;
      if (r.err) exp_err++;
    end
    exp1_valid = acc1;
    if (acc1) exp1 = model(in_data, in_len, in_phv, 1);
    @(posedge clk);
    #1;
    compare();
  endtask

  function automatic logic [HW-1:0] put16(input logic [HW-1:0] d, input int off,
                                          input logic [15:0] v);
    d[HW-1-8*off -: 8]     = v[15:8];
    d[HW-1-8*(off+1) -: 8] = v[7:0];
    return d;
  endfunction

  function automatic logic [HW-1:0] ramp_data();
    logic [HW-1:0] d;
    for (int i = 0; i < 256; i++) d[HW-1-8*i -: 8] = 8'(i);
    return d;
  endfunction

  task automatic rand_beat();
    logic [HW-1:0] d;
    logic [15:0]   inner;
    int            kind;
    int            bl [9] = '{0, 10, 13, 14, 17, 18, 21, 22, 23};
    for (int i = 0; i < HW / 32; i++) d[32*i +: 32] = $urandom();
    case ($urandom_range(0, 4))
      0: inner = 16'h86DD;
      1: inner = 16'h0800;
      2: inner = 16'h0806;
      3: inner = 16'h8100;
      default: inner = 16'($urandom());
    endcase
    kind = $urandom_range(0, 6);
    case (kind)
      0: d = put16(d, 12, inner);
      1: begin d = put16(d, 12, 16'h8100); d = put16(d, 16, inner); end
      2: begin d = put16(d, 12, 16'h88A8); d = put16(d, 16, inner); end
      3: begin d = put16(d, 12, 16'h88A8); d = put16(d, 16, 16'h8100); d = put16(d, 20, inner); end
      4: begin d = put16(d, 12, 16'h8100); d = put16(d, 16, 16'h8100); d = put16(d, 20, 16'h8100); end
      5: begin d = put16(d, 12, 16'h88A8); d = put16(d, 16, 16'h88A8); end
      default: ;
    endcase
    in_data = d;
    if ($urandom_range(0, 9) < 3) in_len = 16'(bl[$urandom_range(0, 8)]);
    else in_len = 16'($urandom_range(0, 300));
    for (int i = 0; i < 13; i++) in_phv[32*i +: 32] = $urandom();
  endtask

  task automatic send_directed(input logic [HW-1:0] d, input logic [15:0] len,
                               input logic [PW-1:0] phv);
    in_data   = d;
    in_len    = len;
    in_phv    = phv;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
  endtask

  initial begin
    logic [HW-1:0] d;
    int base_pkt;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_len = '0; in_data = '0; in_phv = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_pkt", st_pkt, 0);
    chk("rst_out_length", out_len, 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", in_ready, 1);

    // Untagged IPv6
    d = put16(ramp_data(), 12, 16'h86DD);
    send_directed(d, 16'd100, '0);
    chk("ut_len", out_len, 16'd86);
    chk("ut_b6", out_phv[48 +: 8], 8'd14);
    chk("ut_w0", out_phv[88 +: 32], 32'h10);
    chk("ut_byte0", out_data[HW-1 -: 8], 8'h0E);
    chk("ut_ipv6_cnt", st_ipv6, 1);
    step();

    // Single C-tag, IPv4
    d = put16(ramp_data(), 12, 16'h8100);
    d = put16(d, 14, 16'h0123);
    d = put16(d, 16, 16'h0800);
    send_directed(d, 16'd64, '0);
    chk("st_h0", out_phv[56 +: 16], 16'h0123);
    chk("st_w0", out_phv[88 +: 32], 32'h0A);
    chk("st_len", out_len, 16'd46);
    chk("st_b6", out_phv[48 +: 8], 8'd18);
    step();

    // QinQ IPv6; second instance stops after one tag
    d = put16(ramp_data(), 12, 16'h88A8);
    d = put16(d, 14, 16'h0005);
    d = put16(d, 16, 16'h8100);
    d = put16(d, 18, 16'h0007);
    d = put16(d, 20, 16'h86DD);
    send_directed(d, 16'd100, '0);
    chk("qq_h0", out_phv[56 +: 16], 16'd5);
    chk("qq_h1", out_phv[72 +: 16], 16'd7);
    chk("qq_w0", out_phv[88 +: 32], 32'h12);
    chk("qq_len", out_len, 16'd78);
    chk("qq_b6", out_phv[48 +: 8], 8'd22);
    chk("qq1_w0", out_phv1[88 +: 32], 32'h02);
    chk("qq1_len", out_len1, 16'd82);
    chk("qq1_b6", out_phv1[48 +: 8], 8'd18);
    chk("qq1_h1", out_phv1[72 +: 16], 16'd0);
    step();

    // Short frame
    d = put16(ramp_data(), 12, 16'h86DD);
    send_directed(d, 16'd10, 408'h33 << 48);
    chk("sh_w0", out_phv[88 +: 32], 32'h80);
    chk("sh_len", out_len, 16'd10);
    chk("sh_b6", out_phv[48 +: 8], 8'h33);
    chk_wide("sh_data", out_data, d);
    chk("sh_err_cnt", st_err, 1);
    step();

    // Randomised traffic with random backpressure
    for (int c = 0; c < 2000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rand_beat();
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();

    // Backpressure: three back-to-back beats into a stalled output
    base_pkt = exp_pkt;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    rand_beat(); step();
    chk("bp_ready1", in_ready, 1);
    rand_beat(); step();
    chk("bp_ready2", in_ready, 0);
    rand_beat(); step();
    chk("bp_ready3", in_ready, 0);
    chk("bp_accepted", st_pkt, 32'(base_pkt + 2));
    in_valid = 1'b0;
    repeat (2) step();
    out_ready = 1'b1;
    repeat (3) step();

    // Reset with both slots full
    out_ready = 1'b0; in_valid = 1'b1;
    rand_beat(); step();
    rand_beat(); step();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mr_out_valid", out_valid, 0);
    chk("mr_in_ready", in_ready, 0);
    chk("mr_pkt", st_pkt, 0);
    chk("mr_ipv6", st_ipv6, 0);
    chk("mr_err", st_err, 0);
    chk("mr_v1_out_valid", out_valid1, 0);
    q.delete();
    exp_pkt = 0; exp_ipv6 = 0; exp_err = 0; exp1_valid = 0;
    @(posedge clk);
    #1;
    chk("mr_hold_in_ready", in_ready, 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("mr_release_in_ready", in_ready, 1);
    chk("mr_release_out_valid", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
